// File: rtl/sp_access_pkg.sv
// Shared types and derived sizing for the scratchpad access controller.
// Sizing helpers let the top derive its widths from its own parameters.
package sp_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_ACC_RD,
        ST_ACC_WR,
        ST_DONE
    } state_e;

    function automatic int calc_max_dim(input int bus_w, input int data_w);
        return bus_w / data_w;
    endfunction

    function automatic int calc_n_elem(input int bus_w, input int data_w);
        return calc_max_dim(bus_w, data_w) * calc_max_dim(bus_w, data_w);
    endfunction

    function automatic int calc_addr_w(input int bus_w, input int data_w);
        return 2 * $clog2(calc_max_dim(bus_w, data_w));
    endfunction

    localparam int SP_NTARGETS = 4;
    localparam int DATA_WIDTH  = 32;
    localparam int BUS_WIDTH   = 64;
    localparam int MAX_DIM     = calc_max_dim(BUS_WIDTH, DATA_WIDTH);
    localparam int N_ELEM      = calc_n_elem(BUS_WIDTH, DATA_WIDTH);
    localparam int ADDR_W      = calc_addr_w(BUS_WIDTH, DATA_WIDTH);
    localparam int TGT_W       = $clog2(SP_NTARGETS);

endpackage

// File: rtl/sp_lane_adder.sv
// Lane-wise adder: each DATA_WIDTH lane wraps on its own, no carry crosses lanes.
// Purely combinational.
module sp_lane_adder #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64
) (
    input  logic [BUS_WIDTH-1:0] a_i,
    input  logic [BUS_WIDTH-1:0] b_i,
    output logic [BUS_WIDTH-1:0] sum_o
);

    localparam int N_LANES = BUS_WIDTH / DATA_WIDTH;

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        assign sum_o[l*DATA_WIDTH +: DATA_WIDTH] =
            a_i[l*DATA_WIDTH +: DATA_WIDTH] + b_i[l*DATA_WIDTH +: DATA_WIDTH];
    end

endmodule

// File: rtl/sp_access_ctrl.sv
// Sole master of the result scratchpad: sequences engine bursts (overwrite or
// read-modify-write accumulate) and slots host single reads into unused cycles.
module sp_access_ctrl
    import sp_access_pkg::*;
#(
    parameter int SP_NTARGETS  = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int BUS_WIDTH    = 64,
    localparam int N_ELEM      = calc_n_elem(BUS_WIDTH, DATA_WIDTH),
    localparam int ADDR_W      = calc_addr_w(BUS_WIDTH, DATA_WIDTH),
    localparam int TGT_W       = $clog2(SP_NTARGETS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 eng_start_i,
    input  logic [TGT_W-1:0]     eng_target_i,
    input  logic                 eng_bias_i,
    input  logic                 eng_valid_i,
    input  logic [BUS_WIDTH-1:0] eng_data_i,
    output logic                 eng_ready_o,
    output logic                 eng_done_o,
    output logic                 busy_o,

    input  logic                 host_rd_req_i,
    input  logic [TGT_W-1:0]     host_rd_target_i,
    input  logic [ADDR_W-1:0]    host_rd_addr_i,
    output logic                 host_rd_gnt_o,
    output logic                 host_rd_valid_o,
    output logic [BUS_WIDTH-1:0] host_rd_data_o,

    output logic                 sp_we_o,
    output logic                 sp_mode_o,
    output logic [TGT_W-1:0]     sp_write_target_o,
    output logic [TGT_W-1:0]     sp_read_target_o,
    output logic [ADDR_W-1:0]    sp_address_o,
    output logic [BUS_WIDTH-1:0] sp_wdata_o,
    input  logic [BUS_WIDTH-1:0] sp_rdata_i
);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic [TGT_W-1:0]     tgt_q, tgt_d;
    logic [BUS_WIDTH-1:0] old_q, old_d;
    logic                 host_vld_q;
    logic [BUS_WIDTH-1:0] host_dat_q;

    logic [BUS_WIDTH-1:0] acc_sum;
    logic                 eng_use;
    logic                 host_gnt;
    logic                 last_elem;

    assign last_elem = (cnt_q == ADDR_W'(N_ELEM - 1));

    sp_lane_adder #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH)
    ) u_lane_adder (
        .a_i   (old_q),
        .b_i   (eng_data_i),
        .sum_o (acc_sum)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tgt_q      <= '0;
            old_q      <= '0;
            host_vld_q <= 1'b0;
            host_dat_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            old_q      <= old_d;
            host_vld_q <= host_gnt;
            if (host_gnt) begin
                host_dat_q <= sp_rdata_i;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        tgt_d             = tgt_q;
        old_d             = old_q;
        eng_ready_o       = 1'b0;
        eng_done_o        = 1'b0;
        eng_use           = 1'b0;
        host_gnt          = 1'b0;
        sp_we_o           = 1'b0;
        sp_mode_o         = 1'b0;
        sp_write_target_o = '0;
        sp_read_target_o  = '0;
        sp_address_o      = '0;
        sp_wdata_o        = '0;

        case (state_q)
            ST_IDLE: begin
                if (eng_start_i) begin
                    tgt_d   = eng_target_i;
                    cnt_d   = '0;
                    state_d = eng_bias_i ? ST_ACC_RD : ST_WR;
                end
            end
            ST_WR: begin
                eng_ready_o = 1'b1;
                if (eng_valid_i) begin
                    eng_use           = 1'b1;
                    sp_we_o           = 1'b1;
                    sp_write_target_o = tgt_q;
                    sp_address_o      = cnt_q;
                    sp_wdata_o        = eng_data_i;
                    if (last_elem) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ACC_RD: begin
                eng_use          = 1'b1;
                sp_mode_o        = 1'b1;
                sp_read_target_o = tgt_q;
                sp_address_o     = cnt_q;
                old_d            = sp_rdata_i;
                state_d          = ST_ACC_WR;
            end
            ST_ACC_WR: begin
                eng_ready_o = 1'b1;
                if (eng_valid_i) begin
                    eng_use           = 1'b1;
                    sp_we_o           = 1'b1;
                    sp_write_target_o = tgt_q;
                    sp_address_o      = cnt_q;
                    sp_wdata_o        = acc_sum;
                    if (last_elem) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_ACC_RD;
                    end
                end
            end
            ST_DONE: begin
                eng_done_o = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Host only gets cycles the engine leaves unused; reset masks the grant.
        host_gnt = host_rd_req_i && !eng_use && !rst_i;
        if (host_gnt) begin
            sp_mode_o        = 1'b1;
            sp_read_target_o = host_rd_target_i;
            sp_address_o     = host_rd_addr_i;
        end
    end

    assign busy_o          = (state_q != ST_IDLE);
    assign host_rd_gnt_o   = host_gnt;
    assign host_rd_valid_o = host_vld_q;
    assign host_rd_data_o  = host_dat_q;

endmodule

// File: tb/tb_sp_access_ctrl.sv
// Directed bench for sp_access_ctrl: behavioural scratchpad plus a burst-level
// reference of expected writes and host read data, checked every cycle.
module tb_sp_access_ctrl;

    localparam int TW = 2;
    localparam int AW = 2;
    localparam int BW = 64;
    localparam int NE = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          eng_start_i = 1'b0;
    logic [TW-1:0] eng_target_i = '0;
    logic          eng_bias_i = 1'b0;
    logic          eng_valid_i = 1'b0;
    logic [BW-1:0] eng_data_i = '0;
    logic          eng_ready_o, eng_done_o, busy_o;
    logic          host_rd_req_i = 1'b0;
    logic [TW-1:0] host_rd_target_i = '0;
    logic [AW-1:0] host_rd_addr_i = '0;
    logic          host_rd_gnt_o, host_rd_valid_o;
    logic [BW-1:0] host_rd_data_o;
    logic          sp_we_o, sp_mode_o;
    logic [TW-1:0] sp_write_target_o, sp_read_target_o;
    logic [AW-1:0] sp_address_o;
    logic [BW-1:0] sp_wdata_o, sp_rdata_i;

    sp_access_ctrl dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .eng_start_i       (eng_start_i),
        .eng_target_i      (eng_target_i),
        .eng_bias_i        (eng_bias_i),
        .eng_valid_i       (eng_valid_i),
        .eng_data_i        (eng_data_i),
        .eng_ready_o       (eng_ready_o),
        .eng_done_o        (eng_done_o),
        .busy_o            (busy_o),
        .host_rd_req_i     (host_rd_req_i),
        .host_rd_target_i  (host_rd_target_i),
        .host_rd_addr_i    (host_rd_addr_i),
        .host_rd_gnt_o     (host_rd_gnt_o),
        .host_rd_valid_o   (host_rd_valid_o),
        .host_rd_data_o    (host_rd_data_o),
        .sp_we_o           (sp_we_o),
        .sp_mode_o         (sp_mode_o),
        .sp_write_target_o (sp_write_target_o),
        .sp_read_target_o  (sp_read_target_o),
        .sp_address_o      (sp_address_o),
        .sp_wdata_o        (sp_wdata_o),
        .sp_rdata_i        (sp_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Scratchpad behaviour: combinational read, write on the clock edge.
    logic [BW-1:0] sp_mem [4][4];
    always @(posedge clk_i) begin
        if (sp_we_o) sp_mem[sp_write_target_o][sp_address_o] <= sp_wdata_o;
    end
    assign sp_rdata_i = (sp_mode_o && !sp_we_o) ? sp_mem[sp_read_target_o][sp_address_o] : '0;

    typedef struct {
        logic [TW-1:0] t;
        logic [AW-1:0] a;
        logic [BW-1:0] d;
    } wr_t;

    logic [BW-1:0] ref_mem [4][4];
    wr_t           exp_wr[$];
    logic [BW-1:0] exp_rd[$];
    logic [BW-1:0] bdat [NE];
    int            checks = 0;
    int            errors = 0;
    int            wr_cnt = 0;
    int            gnt_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [BW-1:0] lane_add(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = a[31:0] + b[31:0];
        hi = a[63:32] + b[63:32];
        return {hi, lo};
    endfunction

    always @(negedge clk_i) begin
        wr_t w;
        logic [BW-1:0] r;
        if (sp_we_o) begin
            wr_cnt++;
            chk("write_expected", 64'(exp_wr.size() > 0), 64'(1));
            if (exp_wr.size() > 0) begin
                w = exp_wr.pop_front();
                chk("wr_target", 64'(sp_write_target_o), 64'(w.t));
                chk("wr_addr", 64'(sp_address_o), 64'(w.a));
                chk("wr_data", sp_wdata_o, w.d);
            end
        end
        if (host_rd_valid_o) begin
            chk("rd_expected", 64'(exp_rd.size() > 0), 64'(1));
            if (exp_rd.size() > 0) begin
                r = exp_rd.pop_front();
                chk("rd_data", host_rd_data_o, r);
            end
        end
        if (host_rd_gnt_o) begin
            gnt_cnt++;
            chk("gnt_port_free", 64'({sp_we_o, sp_mode_o}), 64'(2'b01));
            chk("gnt_target", 64'(sp_read_target_o), 64'(host_rd_target_i));
            chk("gnt_addr", 64'(sp_address_o), 64'(host_rd_addr_i));
            exp_rd.push_back(ref_mem[host_rd_target_i][host_rd_addr_i]);
        end
        if (!busy_o && !host_rd_gnt_o) begin
            chk("idle_port", 64'(sp_we_o || sp_mode_o || (sp_write_target_o != 0) ||
                (sp_read_target_o != 0) || (sp_address_o != 0) || (sp_wdata_o != 0)), 64'(0));
        end
    end

    task automatic run_burst(input logic [TW-1:0] tgt, input logic bias, input int gap_el,
                             output int t0, output int tdone);
        int el;
        int guard;
        bit gapped;
        bit seen;
        logic [BW-1:0] v;
        @(posedge clk_i); #1;
        eng_start_i  = 1'b1;
        eng_target_i = tgt;
        eng_bias_i   = bias;
        @(negedge clk_i);
        t0 = cyc;
        chk("start_in_idle", 64'(busy_o), 64'(0));
        for (int i = 0; i < NE; i++) begin
            v = bias ? lane_add(ref_mem[tgt][i], bdat[i]) : bdat[i];
            exp_wr.push_back('{t: tgt, a: AW'(i), d: v});
            ref_mem[tgt][i] = v;
        end
        @(posedge clk_i); #1;
        eng_start_i = 1'b0;
        el = 0; gapped = 0; guard = 0;
        while (el < NE && guard < 40) begin
            eng_valid_i = !(el == gap_el && !gapped);
            eng_data_i  = bdat[el];
            @(negedge clk_i);
            if (!eng_valid_i) gapped = 1;
            else if (eng_ready_o) el++;
            guard++;
            @(posedge clk_i); #1;
        end
        eng_valid_i = 1'b0;
        eng_data_i  = '0;
        chk("burst_accepted", 64'(el), 64'(NE));
        seen = 0;
        tdone = -1;
        for (int g = 0; g < 8 && !seen; g++) begin
            @(negedge clk_i);
            if (eng_done_o) begin
                seen = 1;
                tdone = cyc;
            end else begin
                @(posedge clk_i); #1;
            end
        end
        chk("done_seen", 64'(seen), 64'(1));
    endtask

    task automatic host_read(input logic [TW-1:0] t, input logic [AW-1:0] a, input logic [BW-1:0] expv);
        @(posedge clk_i); #1;
        host_rd_req_i = 1'b1; host_rd_target_i = t; host_rd_addr_i = a;
        @(negedge clk_i);
        chk("idle_gnt", 64'(host_rd_gnt_o), 64'(1));
        @(posedge clk_i); #1;
        host_rd_req_i = 1'b0;
        @(negedge clk_i);
        chk("host_valid", 64'(host_rd_valid_o), 64'(1));
        chk("host_data_lit", host_rd_data_o, expv);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("host_valid_one_cycle", 64'(host_rd_valid_o), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, td, w0, g0, gcyc;
        bit got;

        // Reset with a pending host request: grant must stay low.
        host_rd_req_i = 1'b1;
        eng_start_i   = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_gnt", 64'(host_rd_gnt_o), 64'(0));
        chk("rst_outs", 64'({eng_ready_o, eng_done_o, host_rd_valid_o, sp_we_o, sp_mode_o}), 64'(0));
        chk("rst_rdata", host_rd_data_o, 64'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0; host_rd_req_i = 1'b0; eng_start_i = 1'b0;

        // Non-bias target 2, data 1..4, with a stray start mid-burst.
        bdat[0] = 64'd1; bdat[1] = 64'd2; bdat[2] = 64'd3; bdat[3] = 64'd4;
        w0 = wr_cnt;
        fork
            run_burst(2'd2, 1'b0, -1, t0, td);
            begin
                repeat (3) @(posedge clk_i);
                #1 eng_start_i = 1'b1; eng_target_i = 2'd3; eng_bias_i = 1'b1;
                @(posedge clk_i);
                #1 eng_start_i = 1'b0;
            end
        join
        chk("nb_done_time", 64'(td), 64'(t0 + 5));
        chk("nb_writes", 64'(wr_cnt - w0), 64'(4));

        // Preload target 1 and target 3 back-to-back.
        bdat[0] = 64'h00000001_FFFFFFFF; bdat[1] = 64'h10; bdat[2] = 64'h20; bdat[3] = 64'h30;
        run_burst(2'd1, 1'b0, -1, t0, td);
        bdat[0] = 64'h3333_0000; bdat[1] = 64'h3333_0001; bdat[2] = 64'h3333_0002; bdat[3] = 64'h3333_0003;
        run_burst(2'd3, 1'b0, -1, t0, td);

        // Bias accumulate onto target 1.
        bdat[0] = 64'h00000002_00000001; bdat[1] = 64'h00000001_00000001;
        bdat[2] = 64'hFFFFFFFF_FFFFFFFF; bdat[3] = 64'h5;
        w0 = wr_cnt;
        run_burst(2'd1, 1'b1, -1, t0, td);
        chk("bias_done_time", 64'(td), 64'(t0 + 9));
        chk("bias_writes", 64'(wr_cnt - w0), 64'(4));
        host_read(2'd1, 2'd0, 64'h00000003_00000000);
        host_read(2'd1, 2'd1, 64'h00000001_00000011);
        host_read(2'd1, 2'd2, 64'hFFFFFFFF_0000001F);
        host_read(2'd1, 2'd3, 64'h35);

        // Host read during WR with one valid gap before element 1.
        bdat[0] = 64'd5; bdat[1] = 64'd6; bdat[2] = 64'd7; bdat[3] = 64'd8;
        w0 = wr_cnt; g0 = gnt_cnt; gcyc = -1; got = 0;
        fork
            run_burst(2'd2, 1'b0, 1, t0, td);
            begin
                repeat (2) @(posedge clk_i);
                #1 host_rd_req_i = 1'b1; host_rd_target_i = 2'd3; host_rd_addr_i = 2'd2;
                for (int g = 0; g < 10 && !got; g++) begin
                    @(negedge clk_i);
                    if (host_rd_gnt_o) begin
                        got = 1;
                        gcyc = cyc;
                    end else begin
                        @(posedge clk_i); #1;
                    end
                end
                @(posedge clk_i); #1;
                host_rd_req_i = 1'b0;
                @(negedge clk_i);
                chk("gap_rd_valid", 64'(host_rd_valid_o), 64'(1));
                chk("gap_rd_data", host_rd_data_o, 64'h3333_0002);
            end
        join
        chk("gap_gnt_seen", 64'(got), 64'(1));
        chk("gap_gnt_cycle", 64'(gcyc), 64'(t0 + 2));
        chk("gap_gnt_count", 64'(gnt_cnt - g0), 64'(1));
        chk("gap_done_time", 64'(td), 64'(t0 + 6));
        chk("gap_writes", 64'(wr_cnt - w0), 64'(4));
        host_read(2'd2, 2'd3, 64'd8);

        // Reset after two elements of a target-0 burst.
        w0 = wr_cnt;
        bdat[0] = 64'hA0; bdat[1] = 64'hA1; bdat[2] = 64'hA2; bdat[3] = 64'hA3;
        for (int i = 0; i < 2; i++) begin
            exp_wr.push_back('{t: 2'd0, a: AW'(i), d: bdat[i]});
            ref_mem[0][i] = bdat[i];
        end
        @(posedge clk_i); #1;
        eng_start_i = 1'b1; eng_target_i = 2'd0; eng_bias_i = 1'b0;
        @(posedge clk_i); #1;
        eng_start_i = 1'b0; eng_valid_i = 1'b1; eng_data_i = bdat[0];
        @(posedge clk_i); #1;
        eng_data_i = bdat[1];
        @(posedge clk_i); #1;
        rst_i = 1'b1; eng_data_i = bdat[2]; eng_start_i = 1'b1; host_rd_req_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_busy", 64'(busy_o), 64'(0));
        chk("midrst_outs", 64'({eng_ready_o, eng_done_o, host_rd_gnt_o, host_rd_valid_o,
            sp_we_o, sp_mode_o}), 64'(0));
        chk("midrst_bus", 64'((sp_wdata_o != 0) || (sp_address_o != 0) ||
            (sp_write_target_o != 0) || (sp_read_target_o != 0) || (host_rd_data_o != 0)), 64'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0; eng_start_i = 1'b0; eng_valid_i = 1'b0; host_rd_req_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("midrst_writes", 64'(wr_cnt - w0), 64'(2));
        chk("midrst_idle", 64'(busy_o), 64'(0));

        // First start after reset behaves normally.
        bdat[0] = 64'hB0; bdat[1] = 64'hB1; bdat[2] = 64'hB2; bdat[3] = 64'hB3;
        w0 = wr_cnt;
        run_burst(2'd0, 1'b0, -1, t0, td);
        chk("post_rst_done_time", 64'(td), 64'(t0 + 5));
        chk("post_rst_writes", 64'(wr_cnt - w0), 64'(4));
        host_read(2'd0, 2'd2, 64'hB2);

        repeat (2) @(posedge clk_i);
        chk("queues_drained", 64'(exp_wr.size() + exp_rd.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
